// File: rtl/pcs_pkg.sv
// pcs_pkg: shared PCS constants and gearbox state type.
package pcs_pkg;
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;
  localparam int GB_SEQ_N = 33;
  typedef enum logic {IDLE, RUN} gearbox_state_e;
endpackage

// File: rtl/pcs_tx_gearbox_if.sv
// pcs_tx_gearbox_if: upstream half-block input and PMA word output of the TX gearbox.
interface pcs_tx_gearbox_if #(
  parameter int DATA_W = 32,
  parameter int HEAD_W = 2
);
  logic              valid_i;
  logic              head_v_i;
  logic [HEAD_W-1:0] head_i;
  logic [DATA_W-1:0] data_i;
  logic              ready_o;
  logic              data_v_o;
  logic [DATA_W-1:0] data_o;
  logic              misalign_o;
  logic              underrun_o;
  modport master (
    output valid_i, head_v_i, head_i, data_i,
    input  ready_o, data_v_o, data_o, misalign_o, underrun_o
  );
  modport slave (
    input  valid_i, head_v_i, head_i, data_i,
    output ready_o, data_v_o, data_o, misalign_o, underrun_o
  );
endinterface

// File: rtl/pcs_tx_gearbox.sv
// pcs_tx_gearbox: 66b->32b TX gearbox, one PMA word per cycle with a stall every 33rd cycle.
module pcs_tx_gearbox
  import pcs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int HEAD_W = 2,
  parameter int SEQ_N  = GB_SEQ_N,
  parameter int SEQ_W  = $clog2(SEQ_N)
) (
  input logic             clk,
  input logic             nreset,
  pcs_tx_gearbox_if.slave bus
);
  localparam int CW = 2 * DATA_W + HEAD_W;
  localparam int RW = DATA_W + HEAD_W;
  gearbox_state_e    state;
  logic [SEQ_W-1:0]  seq;
  logic [SEQ_W-1:0]  res_cnt;
  logic [RW-1:0]     res;
  logic [CW-1:0]     nw;
  logic [CW-1:0]     comb;
  logic              run, stall, lock, head_ok, under, misal, accept;
  assign run     = state == RUN;
  assign stall   = run && seq == SEQ_W'(SEQ_N - 1);
  assign lock    = !run && bus.valid_i && bus.head_v_i;
  assign head_ok = bus.head_v_i == !seq[0];
  assign under   = run && !stall && !bus.valid_i;
  assign misal   = run && !stall && bus.valid_i && !head_ok;
  assign accept  = lock || (run && !stall && bus.valid_i && head_ok);
  assign bus.ready_o = state == IDLE || seq != SEQ_W'(SEQ_N - 1);
  // residual bits go out first, the new word is appended above them
  assign nw   = bus.head_v_i ? CW'({bus.data_i, bus.head_i}) : CW'(bus.data_i);
  assign comb = (CW'(res) & ((CW'(1) << res_cnt) - CW'(1))) | (nw << res_cnt);
  always_ff @(posedge clk) begin
    if (nreset) begin
      state          <= IDLE;
      seq            <= '0;
      res            <= '0;
      res_cnt        <= '0;
      bus.data_o     <= '0;
      bus.data_v_o   <= 1'b0;
      bus.misalign_o <= 1'b0;
      bus.underrun_o <= 1'b0;
    end else begin
      bus.misalign_o <= misal;
      bus.underrun_o <= under;
      bus.data_v_o   <= accept || stall;
      if (under || misal) begin
        state   <= IDLE;
        seq     <= '0;
        res     <= '0;
        res_cnt <= '0;
      end else if (stall) begin
        bus.data_o <= res[DATA_W-1:0];
        res_cnt    <= '0;
        seq        <= '0;
      end else if (accept) begin
        state      <= RUN;
        bus.data_o <= comb[DATA_W-1:0];
        res        <= comb[CW-1:DATA_W];
        res_cnt    <= res_cnt + (bus.head_v_i ? SEQ_W'(HEAD_W) : '0);
        seq        <= seq + SEQ_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_pcs_tx_gearbox.sv
// tb_pcs_tx_gearbox: bit-stream reference model plus directed and random checks of the TX gearbox.
module tb_pcs_tx_gearbox;
  import pcs_pkg::*;
  logic clk = 1'b0;
  logic nreset = 1'b1;
  always #5 clk = ~clk;
  pcs_tx_gearbox_if bus ();
  pcs_tx_gearbox dut (.clk(clk), .nreset(nreset), .bus(bus));
  int n_chk = 0;
  int n_pass = 0;
  logic m_run = 1'b0;
  int m_pos = 0;
  logic q[$];
  logic tx[$];
  logic rx[$];
  logic e_ready = 1'b1, e_dv = 1'b0, e_mis = 1'b0, e_und = 1'b0;
  logic [31:0] e_data = '0;
  logic chk_en = 1'b0, sb_en = 1'b0, cnt_en = 1'b0;
  int low_cnt = 0;
  logic [65:0] sb_a, sb_b;
  logic [31:0] d0;
  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  always @(negedge clk) if (chk_en) begin
    check("ready", 66'(bus.ready_o), 66'(e_ready));
    check("data_v", 66'(bus.data_v_o), 66'(e_dv));
    check("data", 66'(bus.data_o), 66'(e_data));
    check("misalign", 66'(bus.misalign_o), 66'(e_mis));
    check("underrun", 66'(bus.underrun_o), 66'(e_und));
    if (cnt_en && !bus.ready_o) low_cnt++;
    if (sb_en && bus.data_v_o) begin
      for (int i = 0; i < 32; i++) rx.push_back(bus.data_o[i]);
      while (rx.size() >= 66) begin
        for (int i = 0; i < 66; i++) begin
          sb_a[i] = rx.pop_front();
          sb_b[i] = tx.size() != 0 ? tx.pop_front() : 1'bx;
        end
        check("sb_block", sb_a, sb_b);
      end
    end
  end
  // the serial line: header bits then payload, each LSB first
  task automatic push(input logic hv, input logic [1:0] h, input logic [31:0] d);
    if (hv) for (int i = 0; i < 2; i++) begin
      q.push_back(h[i]);
      if (sb_en) tx.push_back(h[i]);
    end
    for (int i = 0; i < 32; i++) begin
      q.push_back(d[i]);
      if (sb_en) tx.push_back(d[i]);
    end
  endtask
  task automatic pop32();
    for (int i = 0; i < 32; i++) e_data[i] = q.size() != 0 ? q.pop_front() : 1'bx;
    e_dv = 1'b1;
  endtask
  task automatic flush();
    m_run = 1'b0;
    m_pos = 0;
    q.delete();
    e_dv = 1'b0;
  endtask
  task automatic cyc(input logic rst, input logic v, input logic hv, input logic [1:0] h, input logic [31:0] d);
    nreset = rst;
    bus.valid_i = v;
    bus.head_v_i = hv;
    bus.head_i = h;
    bus.data_i = d;
    e_mis = 1'b0;
    e_und = 1'b0;
    if (rst) begin
      flush();
      e_data = '0;
    end else if (m_run && m_pos == 32) begin
      pop32();
      m_pos = 0;
    end else if (m_run && !v) begin
      e_und = 1'b1;
      flush();
    end else if (m_run && hv != (m_pos % 2 == 0)) begin
      e_mis = 1'b1;
      flush();
    end else if ((v && hv) || m_run) begin
      push(hv, h, d);
      pop32();
      m_run = 1'b1;
      m_pos++;
    end else e_dv = 1'b0;
    e_ready = !(m_run && m_pos == 32);
    @(negedge clk);
    #1;
  endtask
  task automatic run_words(input int n, input logic zero);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'b1, m_pos % 2 == 0, zero ? SYNC_CTRL : SYNC_DATA, zero ? 32'h0 : $urandom);
  endtask
  task automatic basic_block(input string tag);
    cyc(1'b0, 1'b1, 1'b1, SYNC_DATA, 32'hAAAAAAAA);
    check({tag, "_w0"}, 66'(bus.data_o), 66'h0AAAAAAA9);
    check({tag, "_v0"}, 66'(bus.data_v_o), 66'(1));
    check({tag, "_rc0"}, 66'(dut.res_cnt), 66'(2));
    cyc(1'b0, 1'b1, 1'b0, 2'b00, 32'h55555555);
    check({tag, "_w1"}, 66'(bus.data_o), 66'h055555556);
    check({tag, "_rc1"}, 66'(dut.res_cnt), 66'(2));
  endtask
  initial begin
    bus.valid_i = 1'b0;
    bus.head_v_i = 1'b0;
    bus.head_i = '0;
    bus.data_i = '0;
    @(negedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) cyc(1'b1, 1'b1, 1'b1, SYNC_DATA, 32'hFFFFFFFF);
    check("rst_data", 66'(bus.data_o), 66'(0));
    check("rst_data_v", 66'(bus.data_v_o), 66'(0));
    check("rst_ready", 66'(bus.ready_o), 66'(1));
    cyc(1'b0, 1'b1, 1'b0, SYNC_DATA, 32'h12345678);
    basic_block("t1");
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    run_words(32, 1'b1);
    check("t2_ready_low", 66'(bus.ready_o), 66'(0));
    cyc(1'b0, 1'b1, 1'b1, SYNC_CTRL, 32'h0);
    check("t2_stall_data", 66'(bus.data_o), 66'(0));
    check("t2_stall_v", 66'(bus.data_v_o), 66'(1));
    check("t2_seq_wrap", 66'(dut.seq), 66'(0));
    cyc(1'b0, 1'b1, 1'b1, SYNC_CTRL, 32'h0);
    check("t2_next", 66'(bus.data_o), 66'h000000002);
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    sb_en = 1'b1;
    cnt_en = 1'b1;
    low_cnt = 0;
    for (int i = 0; i < 3300; i++) begin
      if (!e_ready) cyc(1'b0, 1'($urandom), 1'($urandom), 2'($urandom), $urandom);
      else cyc(1'b0, 1'b1, m_pos % 2 == 0, $urandom_range(0, 1) != 0 ? SYNC_DATA : SYNC_CTRL, $urandom);
    end
    sb_en = 1'b0;
    cnt_en = 1'b0;
    check("t3_ready_low_cnt", 66'(low_cnt), 66'(100));
    check("t3_sb_drained", 66'(tx.size() + rx.size()), 66'(0));
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    run_words(5, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, SYNC_DATA, $urandom);
    check("t4_misalign", 66'(bus.misalign_o), 66'(1));
    check("t4_data_v", 66'(bus.data_v_o), 66'(0));
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    check("t4_pulse_end", 66'(bus.misalign_o), 66'(0));
    d0 = $urandom;
    cyc(1'b0, 1'b1, 1'b1, SYNC_DATA, d0);
    check("t4_relock", 66'(bus.data_o), 66'({d0[29:0], SYNC_DATA}));
    check("t4_relock_v", 66'(bus.data_v_o), 66'(1));
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    run_words(12, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    check("t5_underrun", 66'(bus.underrun_o), 66'(1));
    check("t5_no_misalign", 66'(bus.misalign_o), 66'(0));
    check("t5_ready", 66'(bus.ready_o), 66'(1));
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    check("t5_pulse_end", 66'(bus.underrun_o), 66'(0));
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    run_words(32, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
    check("t5_stall_drop", 66'(bus.underrun_o), 66'(0));
    check("t5_stall_v", 66'(bus.data_v_o), 66'(1));
    cyc(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    run_words(20, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, SYNC_DATA, $urandom);
    check("t6_data", 66'(bus.data_o), 66'(0));
    check("t6_data_v", 66'(bus.data_v_o), 66'(0));
    check("t6_ready", 66'(bus.ready_o), 66'(1));
    basic_block("t6");
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
